// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, width helpers and round/saturate for fir_mc_tdm
package fir_pkg;
  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int chw(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
  // {sat, result}: round half up by frac bits, clamp to a dw-bit signed range
  function automatic logic [64:0] round_sat(input logic signed [127:0] acc, input int frac, input int dw);
    logic signed [127:0] r, hi, lo;
    r = (acc + ((128'sd1 <<< frac) >>> 1)) >>> frac;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return r > hi ? {1'b1, hi[63:0]} : r < lo ? {1'b1, lo[63:0]} : {1'b0, r[63:0]};
  endfunction
endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed multiply-accumulate with clear and enable, registered accumulator
module fir_mac_unit #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int ACC_WIDTH  = 55
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [COEF_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);
  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
  assign prod = a * b;
  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc + ACC_WIDTH'(prod);
endmodule

// File: rtl/fir_mc_tdm.sv
// fir_mc_tdm: time-multiplexed multi-channel FIR, one shared MAC iterating all taps per sample
module fir_mc_tdm import fir_pkg::*; #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 24,
  parameter int NUM_TAPS   = 128,
  parameter int NUM_CH     = 2,
  parameter int FRAC_BITS  = 23,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + clog2(NUM_TAPS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_s_valid,
  output logic                             o_s_ready,
  input  logic signed [DATA_WIDTH-1:0]     iv_s_data,
  input  logic [chw(NUM_CH)-1:0]           iv_s_ch,
  output logic                             o_m_valid,
  input  logic                             i_m_ready,
  output logic signed [DATA_WIDTH-1:0]     ov_m_data,
  output logic [chw(NUM_CH)-1:0]           ov_m_ch,
  output logic                             o_m_sat,
  input  logic                             i_coef_we,
  input  logic [clog2(NUM_TAPS)-1:0]       iv_coef_addr,
  input  logic signed [COEF_WIDTH-1:0]     iv_coef_data,
  output logic                             o_busy
);
  localparam int TW = clog2(NUM_TAPS);
  localparam int CHW = chw(NUM_CH);
  localparam int SA = CHW + TW;
  logic [2:0] state;
  logic [TW-1:0] tap, c_ra, s_idx;
  logic [TW-1:0] wr_ptr [NUM_CH];
  logic [CHW-1:0] ch_q, ch_sel;
  logic [SA-1:0] clr_addr, s_ra, s_wa;
  logic signed [DATA_WIDTH-1:0] smem [NUM_CH*NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] cmem [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] s_rd, s_wd;
  logic signed [COEF_WIDTH-1:0] c_rd;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [64:0] rs;
  logic accept, ch_ok, c_we, s_we, clr_end, mac_end, unused_rs;
  assign o_s_ready = state == ST_IDLE;
  assign o_busy = !o_s_ready;
  assign o_m_valid = state == ST_OUT;
  assign accept = o_s_ready && i_s_valid;
  assign ch_sel = o_s_ready ? iv_s_ch : ch_q;
  assign ch_ok = 32'(ch_sel) < NUM_CH;
  assign c_we = o_s_ready && i_coef_we;
  // reads run one tap ahead so tap k's operands are ready during MAC cycle k
  assign c_ra = state == ST_MAC ? tap + 1'b1 : '0;
  assign s_idx = wr_ptr[ch_sel] - c_ra;
  assign s_ra = {ch_sel, s_idx};
  assign s_we = state == ST_CLEAR || (accept && ch_ok);
  assign s_wa = state == ST_CLEAR ? clr_addr : s_ra;
  assign s_wd = state == ST_CLEAR ? '0 : iv_s_data;
  assign clr_end = clr_addr == SA'(NUM_CH * NUM_TAPS - 1);
  assign mac_end = tap == TW'(NUM_TAPS - 1);
  assign rs = round_sat(128'(acc), FRAC_BITS, DATA_WIDTH);
  assign unused_rs = ^rs[63:DATA_WIDTH];
  // write-first RAMs: the accepted sample and a same-cycle coefficient write feed tap 0
  always_ff @(posedge i_clk) begin
    if (s_we) smem[s_wa] <= s_wd;
    s_rd <= s_we && s_wa == s_ra ? s_wd : smem[s_ra];
    if (c_we) cmem[iv_coef_addr] <= iv_coef_data;
    c_rd <= c_we && iv_coef_addr == c_ra ? iv_coef_data : cmem[c_ra];
  end
  fir_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(i_clk),
    .rst(i_rst),
    .clr(accept),
    .en(state == ST_MAC),
    .a(s_rd),
    .b(c_rd),
    .acc(acc)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= ST_CLEAR;
      clr_addr <= '0;
      tap <= '0;
      ch_q <= '0;
      ov_m_data <= '0;
      ov_m_ch <= '0;
      o_m_sat <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) wr_ptr[i] <= '0;
    end else
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_end) state <= ST_IDLE;
        end
        ST_IDLE: if (accept && ch_ok) begin
          ch_q <= iv_s_ch;
          tap <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          tap <= tap + 1'b1;
          if (mac_end) begin
            wr_ptr[ch_q] <= wr_ptr[ch_q] + 1'b1;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          ov_m_data <= rs[DATA_WIDTH-1:0];
          ov_m_ch <= ch_q;
          o_m_sat <= rs[64];
          state <= ST_OUT;
        end
        ST_OUT: if (i_m_ready) state <= ST_IDLE;
        default: state <= ST_CLEAR;
      endcase
endmodule

// File: tb/tb_fir_mc_tdm.sv
// tb_fir_mc_tdm: directed checks of fir_mc_tdm (default parameters) with immediate assertions
module tb_fir_mc_tdm;
  logic i_clk = 0, i_rst = 1, i_s_valid = 0, i_m_ready = 1, i_coef_we = 0;
  logic [23:0] iv_s_data = '0, iv_coef_data = '0;
  logic [0:0] iv_s_ch = '0;
  logic [6:0] iv_coef_addr = '0;
  logic o_s_ready, o_m_valid, o_m_sat, o_busy;
  logic [23:0] ov_m_data;
  logic [0:0] ov_m_ch;
  int cyc = 0, n_assert = 0, n_fail = 0, t_acc = 0;

  fir_mc_tdm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .iv_s_data(iv_s_data), .iv_s_ch(iv_s_ch), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .ov_m_data(ov_m_data), .ov_m_ch(ov_m_ch), .o_m_sat(o_m_sat), .i_coef_we(i_coef_we),
    .iv_coef_addr(iv_coef_addr), .iv_coef_data(iv_coef_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, expected end before 5 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic ch, input logic [23:0] d, input logic cwe = 0,
                      input logic [6:0] ca = 0, input logic [23:0] cd = 0);
    int n = 0;
    while (!o_s_ready && n < 1000) begin step(); n++; end
    chk("s_ready_wait", o_s_ready, 1);
    i_s_valid = 1; iv_s_ch = ch; iv_s_data = d;
    i_coef_we = cwe; iv_coef_addr = ca; iv_coef_data = cd;
    step();
    t_acc = cyc;
    i_s_valid = 0; i_coef_we = 0;
  endtask

  task automatic recv(input string tag, input logic [23:0] d, input logic ch, input logic sat);
    int n = 0;
    while (!o_m_valid && n < 500) begin step(); n++; end
    chk({tag, "_lat"}, cyc - t_acc + 1, 130);
    chk({tag, "_data"}, ov_m_data, d);
    chk({tag, "_ch"}, ov_m_ch, ch);
    chk({tag, "_sat"}, o_m_sat, sat);
    step();
  endtask

  // mode 0: coef[k]=2(k+1); mode 1: all 0x7FFFFF; mode 2: all zero
  task automatic load(input int mode);
    for (int k = 0; k < 128; k++) begin
      i_coef_we = 1; iv_coef_addr = 7'(k);
      iv_coef_data = mode == 0 ? 24'(2 * (k + 1)) : mode == 1 ? 24'h7FFFFF : 24'h0;
      step();
    end
    i_coef_we = 0;
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_valid"}, o_m_valid, 0);
    chk({tag, "_ready"}, o_s_ready, 0);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_data"}, ov_m_data, 0);
    chk({tag, "_ch"}, ov_m_ch, 0);
    chk({tag, "_sat"}, o_m_sat, 0);
  endtask

  task automatic check_clear(input string tag);
    int n = 0;
    logic v = 0;
    while (!o_s_ready && n < 1000) begin v |= o_m_valid; step(); n++; end
    chk({tag, "_clear_len"}, n, 256);
    chk({tag, "_clear_valid"}, v, 0);
    chk({tag, "_clear_busy"}, o_busy, 0);
  endtask

  initial begin
    step(3);
    i_rst = 0;
    reset_state("rst");
    check_clear("init");
    load(0);
    // impulse 2^22 with coef 2(k+1) gives k+1 after the 23-bit shift; first output held by backpressure
    i_m_ready = 0;
    send(0, 24'h400000);
    for (int n = 0; n < 500 && !o_m_valid; n++) step();
    chk("bp_lat", cyc - t_acc + 1, 130);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", ov_m_data, 1);
      chk("bp_valid", o_m_valid, 1);
      chk("bp_ready", o_s_ready, 0);
      step();
    end
    i_m_ready = 1;
    step();
    chk("bp_release", o_m_valid, 0);
    for (int j = 1; j < 128; j++) begin
      send(0, 24'h0);
      recv($sformatf("imp%0d", j), 24'(j + 1), 0, 0);
    end
    for (int j = 0; j < 16; j++) begin
      send(0, j == 0 ? 24'h400000 : 24'h0);
      recv($sformatf("iso0_%0d", j), 24'(j + 1), 0, 0);
      send(1, 24'h0);
      recv($sformatf("iso1_%0d", j), 24'h0, 1, 0);
    end
    load(1);
    send(1, 24'h7FFFFF); recv("satp0", 24'h7FFFFE, 1, 0);
    send(1, 24'h7FFFFF); recv("satp1", 24'h7FFFFF, 1, 1);
    send(1, 24'h7FFFFF); recv("satp2", 24'h7FFFFF, 1, 1);
    send(0, 24'h800000); recv("satn0", 24'hC00001, 0, 0);
    send(0, 24'h800000); recv("satn1", 24'h800000, 0, 1);
    load(2);
    send(0, 24'h000003, 1, 7'd0, 24'h400000);
    i_coef_we = 1; iv_coef_addr = 7'd0; iv_coef_data = 24'h0;
    step(5);
    i_coef_we = 0;
    recv("rnd_pos", 24'h000002, 0, 0);
    send(0, 24'hFFFFFD); recv("rnd_neg", 24'hFFFFFF, 0, 0);
    load(0);
    send(0, 24'h400000);
    step(50);
    i_rst = 1;
    step();
    i_rst = 0;
    reset_state("mid_rst");
    check_clear("mid");
    for (int j = 0; j < 8; j++) begin
      send(0, j == 0 ? 24'h400000 : 24'h0);
      recv($sformatf("post%0d", j), 24'(j + 1), 0, 0);
    end
    send(1, 24'h7FFFFF); recv("post_ch1", 24'h000002, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
